// File: rtl/mux_pkg.sv
// Shared types for the channel mux / scan sequencer.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_ch_sel.sv
// Combinational channel extractor. Selecting a channel that does not exist
// gives zero data and raises err_o.
module mux_ch_sel #(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*W-1:0] d_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [W-1:0]      y_o,
  output logic              err_o
);

  // Scan all channels; only an in-range match clears the error flag.
  always_comb begin
    y_o   = '0;
    err_o = 1'b1;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(sel_i) == k) begin
        y_o   = d_i[k*W +: W];
        err_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Channel mux with a direct-select mode and a masked scan mode, feeding a
// single registered valid/ready output stage.
module mux_scan_seq
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] d,
  input  logic [SEL_W-1:0]  s,
  input  logic              mode,
  input  logic [N_CH-1:0]   en_mask,
  input  logic              start,
  output logic [W-1:0]      y,
  output logic [SEL_W-1:0]  y_ch,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              sel_err,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [W-1:0]     y_q, y_d;
  logic [SEL_W-1:0] y_ch_q, y_ch_d;
  logic             y_valid_q, y_valid_d;
  logic             sel_err_q, sel_err_d;
  logic             done_q, done_d;

  logic             stage_free;
  logic [SEL_W-1:0] mux_sel;
  logic [W-1:0]     mux_y;
  logic             mux_err;

  assign stage_free = !y_valid_q || y_ready;
  // One extractor serves both modes: the scan counter in SCAN, the latched select otherwise.
  assign mux_sel    = (state_q == ST_SCAN) ? cnt_q : sel_q;

  mux_ch_sel #(
    .N_CH  (N_CH),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_ch_sel (
    .d_i   (d),
    .sel_i (mux_sel),
    .y_o   (mux_y),
    .err_o (mux_err)
  );

  // Next-state, counter and output-stage load decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    sel_err_d = sel_err_q;
    done_d    = 1'b0;
    y_valid_d = y_valid_q && !y_ready;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_SCAN) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end else begin
            state_d = ST_DIRECT;
            sel_d   = s;
          end
        end
      end
      ST_DIRECT: begin
        if (stage_free) begin
          y_d       = mux_y;
          y_ch_d    = sel_q;
          sel_err_d = mux_err;
          y_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (stage_free) begin
          if (en_mask[cnt_q]) begin
            y_d       = mux_y;
            y_ch_d    = cnt_q;
            sel_err_d = 1'b0;
            y_valid_d = 1'b1;
          end
          if (cnt_q == LAST_CH) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + SEL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      sel_err_q <= sel_err_d;
      done_q    <= done_d;
    end
  end

  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;
  assign sel_err = sel_err_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench: a 16-channel instance for direct/scan/backpressure/reset
// cases and a 12-channel instance for out-of-range select.
module tb_mux_scan_seq;

  localparam int unsigned NA = 16;
  localparam int unsigned NB = 12;
  localparam int unsigned W  = 8;
  localparam int unsigned SA = 4;
  localparam int unsigned SB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [NA*W-1:0] d_a;
  logic [SA-1:0]   s_a, ych_a;
  logic            mode_a, start_a, yv_a, yr_a, se_a, busy_a, done_a;
  logic [NA-1:0]   en_a;
  logic [W-1:0]    y_a;

  logic [NB*W-1:0] d_b;
  logic [SB-1:0]   s_b, ych_b;
  logic            mode_b, start_b, yv_b, yr_b, se_b, busy_b, done_b;
  logic [NB-1:0]   en_b;
  logic [W-1:0]    y_b;

  logic [15:0] exp_mask;
  int n_cmp = 0;
  int n_err = 0;

  mux_scan_seq #(.N_CH(NA), .W(W), .SEL_W(SA)) dut_a (
    .clk(clk), .rst(rst), .d(d_a), .s(s_a), .mode(mode_a), .en_mask(en_a),
    .start(start_a), .y(y_a), .y_ch(ych_a), .y_valid(yv_a), .y_ready(yr_a),
    .sel_err(se_a), .busy(busy_a), .done(done_a)
  );

  mux_scan_seq #(.N_CH(NB), .W(W), .SEL_W(SB)) dut_b (
    .clk(clk), .rst(rst), .d(d_b), .s(s_b), .mode(mode_b), .en_mask(en_b),
    .start(start_b), .y(y_b), .y_ch(ych_b), .y_valid(yv_b), .y_ready(yr_b),
    .sel_err(se_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; mode_a = 1'b0; s_a = '0; en_a = '0; yr_a = 1'b1;
    start_b = 1'b0; mode_b = 1'b0; s_b = '0; en_b = '0; yr_b = 1'b1;
    for (int k = 0; k < int'(NA); k++) d_a[k*W +: W] = 8'hA0 + 8'(k);
    for (int k = 0; k < int'(NB); k++) d_b[k*W +: W] = 8'h30 + 8'(k);

    // Reset state
    tick(); tick();
    chk("rst_y", y_a, 0);
    chk("rst_ych", ych_a, 0);
    chk("rst_valid", yv_a, 0);
    chk("rst_selerr", se_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_b_valid", yv_b, 0);
    rst = 1'b0;
    tick();

    // Direct select of channel 5: sample visible two cycles after start
    s_a = 4'd5; mode_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("dir_busy", busy_a, 1);
    chk("dir_valid_early", yv_a, 0);
    tick();
    chk("dir_y", y_a, 8'hA5);
    chk("dir_ych", ych_a, 5);
    chk("dir_valid", yv_a, 1);
    chk("dir_selerr", se_a, 0);
    chk("dir_busy_after", busy_a, 0);
    tick();
    chk("dir_accept_clear", yv_a, 0);

    // Scan with mask 8421: samples on 0,5,10,15, done with channel 15
    exp_mask = 16'h8421;
    en_a = exp_mask; mode_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("scan_busy", busy_a, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (exp_mask[i-1]) begin
        chk("scan_valid", yv_a, 1);
        chk("scan_ych", ych_a, i - 1);
        chk("scan_y", y_a, 8'hA0 + (i - 1));
      end else begin
        chk("scan_novalid", yv_a, 0);
      end
      chk("scan_done", done_a, (i == 16));
      chk("scan_busy_run", busy_a, (i < 16));
    end
    tick();
    chk("scan_done_pulse", done_a, 0);
    chk("scan_final_clear", yv_a, 0);

    // Backpressure on channel 5 for 3 cycles, channel 6 must follow once
    en_a = 16'h0060; mode_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("bp_pre_valid", yv_a, 0);
    end
    tick();
    chk("bp_ch5_valid", yv_a, 1);
    chk("bp_ch5_ych", ych_a, 5);
    yr_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("bp_hold_valid", yv_a, 1);
      chk("bp_hold_ych", ych_a, 5);
      chk("bp_hold_y", y_a, 8'hA5);
      chk("bp_hold_done", done_a, 0);
    end
    yr_a = 1'b1;
    tick();
    chk("bp_ch6_valid", yv_a, 1);
    chk("bp_ch6_ych", ych_a, 6);
    chk("bp_ch6_y", y_a, 8'hA6);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("bp_tail_valid", yv_a, 0);
      chk("bp_tail_done", done_a, (i == 9));
    end

    // Empty mask, with a direct request held during the scan
    en_a = '0; mode_a = 1'b1; start_a = 1'b1;
    tick();
    mode_a = 1'b0; s_a = 4'd3;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("empty_valid", yv_a, 0);
      chk("empty_done", done_a, (i == 16));
    end
    start_a = 1'b0;
    tick();
    chk("empty_idle", busy_a, 0);
    chk("empty_no_direct", yv_a, 0);

    // Reset in the middle of a full scan
    en_a = 16'hFFFF; mode_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("mid_ych", ych_a, i - 1);
      chk("mid_valid", yv_a, 1);
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", yv_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_y", y_a, 0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("post_rst_done", done_a, 0);
      chk("post_rst_busy", busy_a, 0);
    end

    // Out-of-range select on the 12-channel instance, then an in-range one
    s_b = 4'd13; mode_b = 1'b0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    chk("oor_y", y_b, 0);
    chk("oor_selerr", se_b, 1);
    chk("oor_valid", yv_b, 1);
    chk("oor_ych", ych_b, 13);
    tick();
    s_b = 4'd11; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    chk("inr_y", y_b, 8'h3B);
    chk("inr_selerr", se_b, 0);
    chk("inr_ych", ych_b, 11);

    // Reset wins over a simultaneous start
    mode_a = 1'b0; s_a = 4'd2; start_a = 1'b1; rst = 1'b1;
    tick();
    chk("rstpri_busy", busy_a, 0);
    rst = 1'b0; start_a = 1'b0;
    tick();
    chk("rstpri_busy2", busy_a, 0);
    chk("rstpri_valid", yv_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
